// File: rtl/ksa_multiword_adder.sv
// Streaming multi-word adder: W-bit beats, LS beat first, carry chained through one Kogge-Stone adder.
// Optional subtract mode (in_sub port) enabled by defining KSA_MW_SUB_EN.

module KoggeStoneAdder #(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_s,
    output logic         o_cout,
    output logic         o_overflow_flag
);
    localparam int unsigned LV = $clog2(N);

    logic [N-1:0] w_g [0:LV];
    logic [N-1:0] w_p [0:LV];
    logic [N-1:0] w_hp;
    logic [N:0]   w_c;

    // Parallel-prefix carry tree; carry-in folded into bit 0's generate
    always_comb begin
        w_hp    = i_a ^ i_b;
        w_g[0]  = i_a & i_b;
        w_p[0]  = w_hp;
        w_g[0][0] = (i_a[0] & i_b[0]) | (w_hp[0] & i_cin);
        for (int l = 1; l <= int'(LV); l++) begin
            w_g[l] = w_g[l-1];
            w_p[l] = w_p[l-1];
            for (int i = (1 << (l - 1)); i < int'(N); i++) begin
                w_g[l][i] = w_g[l-1][i] | (w_p[l-1][i] & w_g[l-1][i - (1 << (l - 1))]);
                w_p[l][i] = w_p[l-1][i] & w_p[l-1][i - (1 << (l - 1))];
            end
        end
        w_c             = {w_g[LV], i_cin};
        o_s             = w_hp ^ w_c[N-1:0];
        o_cout          = w_c[N];
        o_overflow_flag = w_c[N] ^ w_c[N-1];
    end
endmodule

module ksa_multiword_adder #(
    parameter  int unsigned W         = 64,
    parameter  int unsigned MAX_BEATS = 8,
    localparam int unsigned IW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_cin,
    input  logic          in_last,
`ifdef KSA_MW_SUB_EN
    input  logic          in_sub,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic          out_last,
    output logic [IW-1:0] out_idx,
    output logic          out_cout,
    output logic          out_ovf,
    output logic          out_err
);
    typedef enum logic {ST_FIRST, ST_CONT} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_carry;
    logic          r_err;
    logic [IW-1:0] r_idx;
    logic          w_accept;
    logic          w_first;
    logic          w_sub;
    logic          w_cin;
    logic          w_sat;
    logic [W-1:0]  w_b;
    logic [W-1:0]  w_s;
    logic          w_cout;
    logic          w_ovf;

    assign in_ready = !out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_first  = (r_state == ST_FIRST);
    assign w_sat    = (r_idx == IW'(MAX_BEATS - 1));

`ifdef KSA_MW_SUB_EN
    logic r_sub;
    assign w_sub = w_first ? in_sub : r_sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction is A + ~B + 1; the +1 rides on the first beat's carry-in
    assign w_b   = w_sub ? ~in_b : in_b;
    assign w_cin = w_first ? (w_sub | in_cin) : r_carry;

    KoggeStoneAdder #(.N(W)) u_ksa (
        .i_a             (in_a),
        .i_b             (w_b),
        .i_cin           (w_cin),
        .o_s             (w_s),
        .o_cout          (w_cout),
        .o_overflow_flag (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_FIRST;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) w_state_nxt = in_last ? ST_FIRST : ST_CONT;
    end

    // r_err arms once a non-last beat lands on the final index: every later beat of the op is excess
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_carry <= w_cout;
            if (in_last) begin
                r_idx <= '0;
                r_err <= 1'b0;
            end else if (w_sat) begin
                r_err <= 1'b1;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end

`ifdef KSA_MW_SUB_EN
    always_ff @(posedge clk) begin
        if (rst)                      r_sub <= 1'b0;
        else if (w_accept && w_first) r_sub <= in_sub;
    end
`endif

    // Single output stage: loads on accept, drops valid on a handshake with nothing behind it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            out_sum   <= w_s;
            out_last  <= in_last;
            out_idx   <= r_idx;
            out_cout  <= in_last & w_cout;
            out_ovf   <= in_last & w_ovf;
            out_err   <= r_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ksa_multiword_adder.sv
// Bench for ksa_multiword_adder: W=8/MAX_BEATS=4 scoreboard instance plus a MAX_BEATS=2 instance for index saturation.
module tb_ksa_multiword_adder;
    typedef struct packed {
        logic [7:0] sum;
        logic       last;
        logic [1:0] idx;
        logic       cout;
        logic       ovf;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       last;
        logic       sub;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, in_cin, in_last, in_sub;
    logic [7:0] in_a, in_b, out_sum;
    logic       out_valid, out_ready, out_last, out_cout, out_ovf, out_err;
    logic [1:0] out_idx;

    logic       in_valid2, in_ready2, in_last2, out_valid2, out_last2, out_cout2, out_ovf2, out_err2;
    logic [7:0] out_sum2;
    logic [0:0] out_idx2;

    ksa_multiword_adder #(.W(8), .MAX_BEATS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_last(in_last),
`ifdef KSA_MW_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
        .out_idx(out_idx), .out_cout(out_cout), .out_ovf(out_ovf), .out_err(out_err)
    );

    ksa_multiword_adder #(.W(8), .MAX_BEATS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(8'h00), .in_b(8'h00), .in_cin(1'b0), .in_last(in_last2),
`ifdef KSA_MW_SUB_EN
        .in_sub(1'b0),
`endif
        .out_valid(out_valid2), .out_ready(1'b1), .out_sum(out_sum2), .out_last(out_last2),
        .out_idx(out_idx2), .out_cout(out_cout2), .out_ovf(out_ovf2), .out_err(out_err2)
    );

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic vec_t mv(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                input logic last, input logic sub, input logic [7:0] sum,
                                input logic [1:0] idx, input logic cout, input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.last = last; v.sub = sub;
        v.e.sum = sum; v.e.last = last; v.e.idx = idx;
        v.e.cout = cout; v.e.ovf = ovf; v.e.err = 1'b0;
        return v;
    endfunction

    // Scoreboard: compare every output handshake against the oldest pushed expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", 32'(out_sum), 32'hDEAD);
            end else begin
                e = sb_q.pop_front();
                chk("sum",  32'(out_sum),  32'(e.sum));
                chk("last", 32'(out_last), 32'(e.last));
                chk("idx",  32'(out_idx),  32'(e.idx));
                chk("cout", 32'(out_cout), 32'(e.cout));
                chk("ovf",  32'(out_ovf),  32'(e.ovf));
                chk("err",  32'(out_err),  32'(e.err));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic last, input logic sub, input exp_t e);
        int waited;
        waited = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_last = last; in_sub = sub;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send2(input logic last, input logic idx, input logic err);
        in_valid2 = 1'b1; in_last2 = last;
        @(negedge clk);
        chk("t5_in_ready", 32'(in_ready2), 32'd1);
        @(posedge clk); #1;
        chk("t5_valid", 32'(out_valid2), 32'd1);
        chk("t5_sum",   32'(out_sum2),   32'd0);
        chk("t5_idx",   32'(out_idx2),   32'(idx));
        chk("t5_err",   32'(out_err2),   32'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        exp_t        e;
        int          nb, sp, waited;
        logic [31:0] ra, rb;
        logic [32:0] aa, bb, full, mask;
        logic        rcin, rsub, rcout, rovf;

        // Directed vectors: carry chain, overflow, ignored mid-op cin, full-length op
        vecs.push_back(mv(8'hFF, 8'h01, 0, 0, 0, 8'h00, 2'd0, 0, 0));
        vecs.push_back(mv(8'h00, 8'h00, 0, 1, 0, 8'h01, 2'd1, 0, 0));
        vecs.push_back(mv(8'h7F, 8'h01, 0, 1, 0, 8'h80, 2'd0, 0, 1));
        vecs.push_back(mv(8'h80, 8'h80, 0, 1, 0, 8'h00, 2'd0, 1, 1));
        vecs.push_back(mv(8'hFF, 8'h00, 1, 0, 0, 8'h00, 2'd0, 0, 0));
        vecs.push_back(mv(8'hFF, 8'h00, 0, 0, 0, 8'h00, 2'd1, 0, 0));
        vecs.push_back(mv(8'h7F, 8'h00, 0, 1, 0, 8'h80, 2'd2, 0, 1));
        vecs.push_back(mv(8'h10, 8'h20, 0, 0, 0, 8'h30, 2'd0, 0, 0));
        vecs.push_back(mv(8'h00, 8'h00, 1, 1, 0, 8'h00, 2'd1, 0, 0));
        vecs.push_back(mv(8'h01, 8'h01, 0, 0, 0, 8'h02, 2'd0, 0, 0));
        vecs.push_back(mv(8'h02, 8'h02, 1, 0, 0, 8'h04, 2'd1, 0, 0));
        vecs.push_back(mv(8'h03, 8'h03, 0, 0, 0, 8'h06, 2'd2, 0, 0));
        vecs.push_back(mv(8'h04, 8'h04, 0, 1, 0, 8'h08, 2'd3, 0, 0));
        vecs.push_back(mv(8'hFF, 8'h00, 1, 1, 0, 8'h00, 2'd0, 1, 0));
        vecs.push_back(mv(8'hFF, 8'hFF, 1, 1, 0, 8'hFF, 2'd0, 1, 0));
`ifdef KSA_MW_SUB_EN
        vecs.push_back(mv(8'h05, 8'h07, 0, 1, 1, 8'hFE, 2'd0, 0, 0));
        vecs.push_back(mv(8'h80, 8'h01, 0, 1, 1, 8'h7F, 2'd0, 1, 1));
        vecs.push_back(mv(8'h00, 8'h01, 1, 0, 1, 8'hFF, 2'd0, 0, 0));
        vecs.push_back(mv(8'h01, 8'h00, 0, 1, 0, 8'h00, 2'd1, 1, 0));
        vecs.push_back(mv(8'h05, 8'h03, 0, 0, 0, 8'h08, 2'd0, 0, 0));
        vecs.push_back(mv(8'h00, 8'h00, 0, 1, 1, 8'h00, 2'd1, 0, 0));
`endif

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        in_last = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_last2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_out_flags", 32'({out_last, out_cout, out_ovf, out_err}), 32'd0);
        chk("rst_valid2",    32'(out_valid2), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready",  32'(in_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++)
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].last, vecs[i].sub, vecs[i].e);
        idle();

        // Backpressure: output held and input stalled while out_ready is low
        out_ready = 1'b0;
        send(8'h12, 8'h34, 0, 1, 0, mv(8'h12, 8'h34, 0, 1, 0, 8'h46, 2'd0, 0, 0).e);
        in_valid = 1'b1; in_a = 8'h20; in_b = 8'h22; in_cin = 1'b0; in_last = 1'b1; in_sub = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_sum",   32'(out_sum),   32'h46);
            chk("bp_out_last",  32'(out_last),  32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'h20, 8'h22, 0, 1, 0, mv(8'h20, 8'h22, 0, 1, 0, 8'h42, 2'd0, 0, 0).e);
        send(8'h01, 8'h02, 0, 1, 0, mv(8'h01, 8'h02, 0, 1, 0, 8'h03, 2'd0, 0, 0).e);
        idle();

        // Reset in the middle of an operation discards carry and index
        send(8'hFF, 8'h01, 0, 0, 0, mv(8'hFF, 8'h01, 0, 0, 0, 8'h00, 2'd0, 0, 0).e);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("valid_after_rst", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        send(8'h00, 8'h00, 0, 1, 0, mv(8'h00, 8'h00, 0, 1, 0, 8'h00, 2'd0, 0, 0).e);
        idle();

        // Random multi-word operations against a wide-arithmetic model
        for (int k = 0; k < 24; k++) begin
            nb   = int'($urandom_range(1, 4));
            ra   = $urandom;
            rb   = $urandom;
            rcin = 1'($urandom_range(0, 1));
            rsub = 1'b0;
`ifdef KSA_MW_SUB_EN
            rsub = 1'($urandom_range(0, 1));
`endif
            mask = (33'h1 << (8 * nb)) - 33'h1;
            aa   = {1'b0, ra} & mask;
            bb   = {1'b0, rb} & mask;
            sp   = 8 * nb - 1;
            if (rsub) begin
                full  = (aa - bb) & mask;
                rcout = (aa >= bb);
                rovf  = (aa[sp] != bb[sp]) && (full[sp] != aa[sp]);
            end else begin
                full  = aa + bb + 33'(rcin);
                rcout = full[8 * nb];
                rovf  = (aa[sp] == bb[sp]) && (full[sp] != aa[sp]);
            end
            for (int j = 0; j < nb; j++) begin
                e.sum  = full[8 * j +: 8];
                e.last = (j == nb - 1);
                e.idx  = 2'(j);
                e.cout = e.last & rcout;
                e.ovf  = e.last & rovf;
                e.err  = 1'b0;
                send(ra[8 * j +: 8], rb[8 * j +: 8], (j == 0) ? rcin : 1'($urandom_range(0, 1)),
                     e.last, (j == 0) ? rsub : 1'($urandom_range(0, 1)), e);
            end
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        // Index saturation on the two-beat instance
        send2(1'b0, 1'b0, 1'b0);
        send2(1'b0, 1'b1, 1'b0);
        send2(1'b1, 1'b1, 1'b1);
        send2(1'b1, 1'b0, 1'b0);
        in_valid2 = 1'b0;
        @(posedge clk); #1;
        chk("t5_valid_drop", 32'(out_valid2), 32'd0);

        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            waited++;
            @(posedge clk); #1;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
